// File: rtl/uop_dispatch.sv
// uop_dispatch: DEPTH-entry uop FIFO feeding a single non-pipelined execution unit with per-uop occupancy.
// Optional same-cycle IDLE bypass from prev_valid/in_uop to out_valid/out_uop when UOP_DISPATCH_BYPASS_EN is defined.
module uop_dispatch #(
    parameter int UOP_W = 32,
    parameter int DEPTH = 4,
    parameter int LAT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enabled,
    input  logic             prev_valid,
    input  logic [UOP_W-1:0] in_uop,
    input  logic [LAT_W-1:0] in_lat,
    output logic             stalled,
    output logic             out_valid,
    output logic [UOP_W-1:0] out_uop,
    input  logic             out_ready,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, READY, BUSY} state_t;

    state_t           state, state_nx;
    logic [UOP_W-1:0] mem_uop [DEPTH];
    logic [LAT_W-1:0] mem_lat [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count, count_nx;
    logic [LAT_W-1:0] busy_cnt, pop_lat;
    logic             push, pop, byp, byp_take, wr;

    assign stalled  = (count == (AW+1)'(DEPTH)) || !enabled;
    assign push     = prev_valid && !stalled;
    assign pop      = (state == READY) && enabled && out_ready;
`ifdef UOP_DISPATCH_BYPASS_EN
    assign byp      = (state == IDLE) && (count == '0) && push;
`else
    assign byp      = 1'b0;
`endif
    assign byp_take = byp && out_ready;
    assign wr       = push && !byp_take;
    assign count_nx = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    assign pop_lat  = mem_lat[rd_ptr];
    assign busy     = busy_cnt != '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            busy_cnt <= '0;
        end else if (enabled) begin
            state    <= state_nx;
            count    <= count_nx;
            wr_ptr   <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            busy_cnt <= pop ? pop_lat : byp_take ? in_lat : busy ? busy_cnt - LAT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !reset && !clear) begin
            mem_uop[wr_ptr] <= in_uop;
            mem_lat[wr_ptr] <= in_lat;
        end
    end

    // BUSY releases while busy_cnt is 2 so the unit is READY during the final busy cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = byp_take ? (in_lat > LAT_W'(1) ? BUSY : IDLE) : (wr ? READY : IDLE);
            READY:   state_nx = !pop ? READY : pop_lat > LAT_W'(1) ? BUSY : count_nx != '0 ? READY : IDLE;
            BUSY:    state_nx = busy_cnt > LAT_W'(2) ? BUSY : count_nx != '0 ? READY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == READY) && enabled;
        out_uop   = out_valid ? mem_uop[rd_ptr] : '0;
        if (byp) begin
            out_valid = 1'b1;
            out_uop   = in_uop;
        end
    end
endmodule

// File: tb/tb_uop_dispatch.sv
// tb_uop_dispatch: directed table vectors plus hand sequences for reset, stall, wrap and bypass corners.
module tb_uop_dispatch;
    logic        clk, reset, clear, enabled, prev_valid, out_ready;
    logic [31:0] in_uop, out_uop;
    logic [5:0]  in_lat;
    logic        stalled, out_valid, busy;
    int          total = 0, bad = 0;

    uop_dispatch dut (
        .clk(clk), .reset(reset), .clear(clear), .enabled(enabled),
        .prev_valid(prev_valid), .in_uop(in_uop), .in_lat(in_lat),
        .stalled(stalled), .out_valid(out_valid), .out_uop(out_uop),
        .out_ready(out_ready), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        bit rs, cl, en, pv, rd, byp;
        logic [31:0] u;
        logic [5:0] l;
        bit st, ov, bz;
        logic [31:0] ou;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(bit rs, bit cl, bit en, bit pv, logic [31:0] u, logic [5:0] l,
                                bit rd, bit st, bit ov, logic [31:0] ou, bit bz, bit byp);
        vec_t v;
        v.rs = rs; v.cl = cl; v.en = en; v.pv = pv; v.u = u; v.l = l; v.rd = rd;
        v.st = st; v.ov = ov; v.ou = ou; v.bz = bz; v.byp = byp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic nxt(input bit rs, input bit cl, input bit en, input bit pv,
                       input logic [31:0] u, input logic [5:0] l, input bit rd);
        @(negedge clk);
        reset = rs; clear = cl; enabled = en; prev_valid = pv; in_uop = u; in_lat = l; out_ready = rd;
        #1;
    endtask

    initial begin
        logic ev;
        logic [31:0] eu;
        reset = 1; clear = 0; enabled = 0; prev_valid = 0; in_uop = 0; in_lat = 0; out_ready = 0;
        //             rs cl en pv uop           lat rd  st ov out_uop       bz byp
        tbl[0]  = mk(0, 0, 1, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 32'hA0000001, 3, 0,  0, 0, 32'h0,        0, 1);
        tbl[2]  = mk(0, 0, 1, 1, 32'hB0000002, 0, 0,  0, 1, 32'hA0000001, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 32'hC0000003, 0, 0,  0, 1, 32'hA0000001, 0, 0);
        tbl[4]  = mk(0, 0, 1, 1, 32'hD0000004, 0, 0,  0, 1, 32'hA0000001, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 32'hE0000005, 0, 0,  1, 1, 32'hA0000001, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 32'h0,        0, 1,  1, 1, 32'hA0000001, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        1, 0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        1, 0);
        tbl[10] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'hB0000002, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'hC0000003, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'hD0000004, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 0);
        tbl[14] = mk(0, 0, 1, 1, 32'hF0000006, 1, 0,  0, 0, 32'h0,        0, 1);
        tbl[15] = mk(0, 0, 1, 1, 32'h10000007, 2, 1,  0, 1, 32'hF0000006, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'h10000007, 1, 0);
        tbl[17] = mk(0, 0, 1, 1, 32'h20000008, 0, 1,  0, 0, 32'h0,        1, 0);
        tbl[18] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'h20000008, 1, 0);
        tbl[19] = mk(0, 0, 1, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 0);
        tbl[20] = mk(0, 0, 1, 1, 32'h30000009, 0, 0,  0, 0, 32'h0,        0, 1);
        tbl[21] = mk(0, 1, 1, 1, 32'h4000000A, 0, 1,  0, 1, 32'h30000009, 0, 0);
        tbl[22] = mk(0, 0, 1, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 0);
        tbl[23] = mk(0, 0, 1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            nxt(tbl[i].rs, tbl[i].cl, tbl[i].en, tbl[i].pv, tbl[i].u, tbl[i].l, tbl[i].rd);
            ev = tbl[i].ov;
            eu = tbl[i].ou;
`ifdef UOP_DISPATCH_BYPASS_EN
            if (tbl[i].byp) begin ev = 1; eu = tbl[i].u; end
`endif
            chk($sformatf("row%0d.stalled", i), 32'(stalled), 32'(tbl[i].st));
            chk($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(ev));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].bz));
            if (ev) chk($sformatf("row%0d.out_uop", i), out_uop, eu);
        end

        // reset mid-operation: 3 buffered uops, busy_cnt=5
        nxt(0, 0, 1, 1, 32'h50, 5, 0);
        nxt(0, 0, 1, 1, 32'h51, 0, 0);
        nxt(0, 0, 1, 1, 32'h52, 0, 0);
        nxt(0, 0, 1, 1, 32'h53, 0, 0);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("rst.pre_uop", out_uop, 32'h50);
        nxt(1, 0, 1, 0, 0, 0, 0);
        chk("rst.pre_busy", 32'(busy), 1);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("rst.stalled", 32'(stalled), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("rst.empty", 32'(out_valid), 0);

        // enable freeze while BUSY with busy_cnt=2
        nxt(0, 0, 1, 1, 32'h60, 3, 0);
        nxt(0, 0, 1, 1, 32'h61, 0, 0);
        chk("frz.head", out_uop, 32'h60);
        nxt(0, 0, 1, 0, 0, 0, 1);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("frz.busy3", 32'(busy), 1);
        for (int k = 0; k < 3; k++) begin
            nxt(0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("frz%0d.stalled", k), 32'(stalled), 1);
            chk($sformatf("frz%0d.out_valid", k), 32'(out_valid), 0);
            chk($sformatf("frz%0d.busy", k), 32'(busy), 1);
        end
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("frz.cnt2_valid", 32'(out_valid), 0);
        chk("frz.cnt2_busy", 32'(busy), 1);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("frz.resume_valid", 32'(out_valid), 1);
        chk("frz.resume_uop", out_uop, 32'h61);
        chk("frz.cnt1_busy", 32'(busy), 1);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("frz.done_busy", 32'(busy), 0);
        chk("frz.done_valid", 32'(out_valid), 0);

        // wrap: count held at 2 with push+pop every cycle
        nxt(0, 0, 1, 1, 32'h100, 0, 0);
        nxt(0, 0, 1, 1, 32'h101, 0, 0);
        chk("wrap.head0", out_uop, 32'h100);
        for (int k = 0; k < 10; k++) begin
            nxt(0, 0, 1, 1, 32'h102 + 32'(k), 0, 1);
            chk($sformatf("wrap%0d.uop", k), out_uop, 32'h100 + 32'(k));
            chk($sformatf("wrap%0d.stalled", k), 32'(stalled), 0);
        end
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("wrap.drain0", out_uop, 32'h10A);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("wrap.drain1", out_uop, 32'h10B);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("wrap.empty", 32'(out_valid), 0);

        // IDLE latency: same-cycle with bypass, one cycle without
        nxt(0, 0, 1, 1, 32'h200, 0, 1);
`ifdef UOP_DISPATCH_BYPASS_EN
        chk("byp.valid", 32'(out_valid), 1);
        chk("byp.uop", out_uop, 32'h200);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("byp.consumed", 32'(out_valid), 0);
        nxt(0, 0, 1, 1, 32'h201, 0, 0);
        chk("byp.show", out_uop, 32'h201);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("byp.buffered", out_uop, 32'h201);
`else
        chk("lat.same_cycle", 32'(out_valid), 0);
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("lat.valid", 32'(out_valid), 1);
        chk("lat.uop", out_uop, 32'h200);
`endif
        nxt(0, 0, 1, 0, 0, 0, 1);
        chk("lat.empty", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
